enemy_fire_scheduler: RTL

Decides which living enemy fires next and when, and hands each shot to the enemy-bullet unit through a request/acknowledge handshake. Sits between the game engine (alive bitmap, run state, random seed) and the pool of enemy bullet slots. Enforces a cooldown between shots and never assigns a shot to an occupied slot or a dead enemy.

---
 rtl/enemy_fire_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/enemy_fire_scheduler.sv
// Picks the next living enemy to fire after a cooldown, assigns it a free bullet slot,
// and holds a registered request until the bullet unit acknowledges or the shot is cancelled.
module enemy_fire_scheduler #(
  parameter int COOLDOWN   = 1000000,
  parameter int SLOT_COUNT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [99:0]           enemy_vivos,
  input  logic [6:0]            n_enemy,
  input  logic [6:0]            seed,
  input  logic [SLOT_COUNT-1:0] slot_free,
  input  logic                  fire_ack,
  output logic                  fire_req,
  output logic [1:0]            fire_slot,
  output logic [6:0]            shooter_id,
  output logic [1:0]            shooter_row,
  output logic [7:0]            shots_fired
);

  typedef enum logic [1:0] {IDLE, SCAN, REQ} state_t;

  localparam logic [19:0] CD = 20'(COOLDOWN);

  state_t      state, state_nx;
  logic [19:0] cnt, cnt_nx;
  logic [6:0]  idx, idx_nx;
  logic [6:0]  probes, probes_nx;
  logic        req_nx;
  logic [1:0]  slot_nx;
  logic [6:0]  id_nx;
  logic [1:0]  row_nx;
  logic [7:0]  shots_nx;

  logic [6:0]  n_eff;
  logic [3:0]  slot_pad;
  logic [1:0]  slot_low;
  logic        probe_alive;
  logic        shooter_alive;

  assign n_eff = (n_enemy > 7'd100) ? 7'd100 : n_enemy;

  // Pad slot_free to four bits so fire_slot can index it for any SLOT_COUNT.
  always_comb begin
    slot_pad = 4'd0;
    slot_low = 2'd0;
    for (int i = 0; i < SLOT_COUNT; i++) slot_pad[i] = slot_free[i];
    for (int i = SLOT_COUNT - 1; i >= 0; i--) begin
      if (slot_free[i]) slot_low = 2'(i);
    end
  end

  assign probe_alive   = (idx < 7'd100) ? enemy_vivos[idx] : 1'b0;
  assign shooter_alive = (shooter_id < 7'd100) ? enemy_vivos[shooter_id] : 1'b0;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    idx_nx    = idx;
    probes_nx = probes;
    req_nx    = fire_req;
    slot_nx   = fire_slot;
    id_nx     = shooter_id;
    row_nx    = shooter_row;
    shots_nx  = shots_fired;
    case (state)
      IDLE: begin
        if (enable) begin
          if (cnt != CD) begin
            cnt_nx = cnt + 20'd1;
          end else if (|slot_free && n_eff != 7'd0) begin
            state_nx  = SCAN;
            idx_nx    = (seed < n_eff) ? seed : 7'd0;
            probes_nx = 7'd0;
            slot_nx   = slot_low;
          end
        end
      end
      SCAN: begin
        if (!enable) begin
          state_nx = IDLE;
          cnt_nx   = 20'd0;
        end else if (probe_alive) begin
          state_nx = REQ;
          req_nx   = 1'b1;
          id_nx    = idx;
          row_nx   = (idx < 7'd8) ? 2'd0 : (idx < 7'd16) ? 2'd1 : 2'd2;
        end else if (probes + 7'd1 >= n_eff) begin
          // Every enemy in play was dead: give up and restart the cooldown.
          state_nx = IDLE;
          cnt_nx   = 20'd0;
        end else begin
          idx_nx    = (idx + 7'd1 >= n_eff) ? 7'd0 : idx + 7'd1;
          probes_nx = probes + 7'd1;
        end
      end
      REQ: begin
        if (!enable) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          cnt_nx   = 20'd0;
        end else if (fire_ack) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          cnt_nx   = 20'd0;
          shots_nx = shots_fired + 8'd1;
        end else if (!shooter_alive || !slot_pad[fire_slot]) begin
          state_nx = IDLE;
          req_nx   = 1'b0;
          cnt_nx   = 20'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        req_nx   = 1'b0;
        cnt_nx   = 20'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 20'd0;
      idx         <= 7'd0;
      probes      <= 7'd0;
      fire_req    <= 1'b0;
      fire_slot   <= 2'd0;
      shooter_id  <= 7'd0;
      shooter_row <= 2'd0;
      shots_fired <= 8'd0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      idx         <= idx_nx;
      probes      <= probes_nx;
      fire_req    <= req_nx;
      fire_slot   <= slot_nx;
      shooter_id  <= id_nx;
      shooter_row <= row_nx;
      shots_fired <= shots_nx;
    end
  end

endmodule
